// File: rtl/avalon_mm_cmd_master.sv
// Avalon-MM initiator: turns a valid/ready command stream into single-word
// bus accesses, one outstanding at a time, with a bounded waitrequest timeout.
module avalon_mm_cmd_master #(
    parameter int ADDR_WIDTH     = 2,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_address,
    input  logic [DATA_WIDTH-1:0] cmd_writedata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_readdata,
    output logic                  rsp_timeout,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] avm_address,
    output logic                  avm_chipselect,
    output logic                  avm_write_n,
    output logic                  avm_read_n,
    output logic [DATA_WIDTH-1:0] avm_writedata,
    input  logic [DATA_WIDTH-1:0] avm_readdata,
    input  logic                  avm_waitrequest
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_TERM =
        CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  cs_q, cs_d;
    logic                  wn_q, wn_d;
    logic                  rn_q, rn_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  tmo_q, tmo_d;
    logic                  done;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cs_d    = cs_q;
        wn_d    = wn_q;
        rn_d    = rn_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        tmo_d   = tmo_q;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d = ACCESS;
                    cnt_d   = '0;
                    cs_d    = 1'b1;
                    wn_d    = ~cmd_write;
                    rn_d    = cmd_write;
                    addr_d  = cmd_address;
                    wdata_d = cmd_writedata;
                    tmo_d   = 1'b0;
                end
            end
            ACCESS: begin
                if (!avm_waitrequest) begin
                    done    = 1'b1;
                    rdata_d = rn_q ? '0 : avm_readdata;
                end else if (TMO_EN && cnt_q == CNT_TERM) begin
                    done    = 1'b1;
                    rdata_d = '0;
                    tmo_d   = 1'b1;
                end else if (cnt_q != '1) begin
                    // saturates so a disabled timeout never wraps
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (done) begin
            state_d = RESP;
            cs_d    = 1'b0;
            wn_d    = 1'b1;
            rn_d    = 1'b1;
            addr_d  = '0;
            wdata_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cs_q    <= 1'b0;
            wn_q    <= 1'b1;
            rn_q    <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cs_q    <= cs_d;
            wn_q    <= wn_d;
            rn_q    <= rn_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            tmo_q   <= tmo_d;
        end
    end

    assign cmd_ready      = (state_q == IDLE);
    assign busy           = (state_q != IDLE);
    assign rsp_valid      = (state_q == RESP);
    assign rsp_readdata   = rdata_q;
    assign rsp_timeout    = tmo_q;
    assign avm_chipselect = cs_q;
    assign avm_write_n    = wn_q;
    assign avm_read_n     = rn_q;
    assign avm_address    = addr_q;
    assign avm_writedata  = wdata_q;

endmodule

// File: tb/tb_avalon_mm_cmd_master.sv
// Bench for avalon_mm_cmd_master: transaction-level model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_avalon_mm_cmd_master;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [1:0]  cmd_address;
    logic [31:0] cmd_writedata;
    logic        rsp_valid;
    logic [31:0] rsp_readdata;
    logic        rsp_timeout;
    logic        busy;
    logic [1:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic        avm_read_n;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    avalon_mm_cmd_master #(
        .ADDR_WIDTH(2),
        .DATA_WIDTH(32),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_address(cmd_address),
        .cmd_writedata(cmd_writedata),
        .rsp_valid(rsp_valid),
        .rsp_readdata(rsp_readdata),
        .rsp_timeout(rsp_timeout),
        .busy(busy),
        .avm_address(avm_address),
        .avm_chipselect(avm_chipselect),
        .avm_write_n(avm_write_n),
        .avm_read_n(avm_read_n),
        .avm_writedata(avm_writedata),
        .avm_readdata(avm_readdata),
        .avm_waitrequest(avm_waitrequest)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int bus_cyc = 0;
    int stall_n = 0;
    logic stuck = 1'b0;
    logic started = 1'b0;
    logic [31:0] slv_mem [4];

    // slave: zero-latency read table, waitrequest for the first stall_n bus cycles
    assign avm_readdata    = slv_mem[avm_address];
    assign avm_waitrequest = stuck || (avm_chipselect && bus_cyc < stall_n);

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        bus_cyc <= avm_chipselect ? bus_cyc + 1 : 0;
    end

    task automatic check(input string nm, input logic [79:0] act,
                         input logic [79:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    // transaction model: in-flight command, bus cycles elapsed, response pending
    logic        m_inbus = 1'b0;
    logic        m_resp = 1'b0;
    logic        m_to = 1'b0;
    logic        m_w = 1'b0;
    logic [1:0]  m_a = '0;
    logic [31:0] m_d = '0;
    logic [31:0] m_rdata = '0;
    int          m_n = 0;

    always @(posedge clk) begin
        if (reset) begin
            started = 1'b1;
            m_inbus = 1'b0;
            m_resp  = 1'b0;
            m_to    = 1'b0;
            m_rdata = '0;
        end else if (m_resp) begin
            m_resp = 1'b0;
        end else if (!m_inbus) begin
            if (cmd_valid) begin
                m_inbus = 1'b1;
                m_n     = 0;
                m_w     = cmd_write;
                m_a     = cmd_address;
                m_d     = cmd_writedata;
                m_to    = 1'b0;
            end
        end else begin
            m_n = m_n + 1;
            if (!avm_waitrequest) begin
                m_inbus = 1'b0;
                m_resp  = 1'b1;
                m_rdata = m_w ? 32'h0 : slv_mem[m_a];
            end else if (m_n == T) begin
                m_inbus = 1'b0;
                m_resp  = 1'b1;
                m_to    = 1'b1;
                m_rdata = 32'h0;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("cycle",
                80'({cmd_ready, rsp_valid, rsp_timeout, busy, avm_chipselect,
                     avm_write_n, avm_read_n, avm_address, avm_writedata,
                     rsp_readdata}),
                80'({!m_inbus && !m_resp, m_resp, m_to, m_inbus || m_resp,
                     m_inbus, !(m_inbus && m_w), !(m_inbus && !m_w),
                     m_inbus ? m_a : 2'b00, m_inbus ? m_d : 32'h0,
                     m_rdata}));
        end
    end

    task automatic send(input logic w, input logic [1:0] a,
                        input logic [31:0] d, input int stall,
                        output int cs_n, output logic [31:0] rd,
                        output logic to);
        int k;
        @(negedge clk);
        cmd_valid     = 1'b1;
        cmd_write     = w;
        cmd_address   = a;
        cmd_writedata = d;
        stall_n       = stall;
        k = 0;
        while (!cmd_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("accept", 80'(cmd_ready), 80'(1));
        @(negedge clk);
        cmd_valid = 1'b0;
        cs_n = 0;
        k = 0;
        while (!rsp_valid && k < 50) begin
            if (avm_chipselect) cs_n++;
            @(negedge clk);
            k++;
        end
        check("rsp_seen", 80'(rsp_valid), 80'(1));
        rd = rsp_readdata;
        to = rsp_timeout;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cs_n;
        logic [31:0] rd;
        logic to;
        int acc1;
        int acc2;
        int pulses;

        slv_mem[0] = 32'h0000_0001;
        slv_mem[1] = 32'h0000_0000;
        slv_mem[2] = 32'hDEAD_BEEF;
        slv_mem[3] = 32'h1234_5678;
        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_address = '0;
        cmd_writedata = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", 80'(cmd_ready), 80'(1));
        check("rst_bus", 80'({avm_chipselect, avm_write_n, avm_read_n}),
              80'(3'b011));
        reset = 1'b0;

        send(1'b1, 2'd0, 32'h1, 0, cs_n, rd, to);
        check("wr_cs_cycles", 80'(cs_n), 80'(1));
        check("wr_rsp", 80'({to, rd}), 80'(33'h0));
        @(negedge clk);
        check("wr_ready_back", 80'(cmd_ready), 80'(1));

        send(1'b0, 2'd0, 32'h0, 0, cs_n, rd, to);
        check("rd0_cs_cycles", 80'(cs_n), 80'(1));
        check("rd0_data", 80'(rd), 80'(32'h1));
        send(1'b0, 2'd1, 32'h0, 0, cs_n, rd, to);
        check("rd1_data", 80'(rd), 80'(32'h0));

        send(1'b1, 2'd2, 32'hA5A5_A5A5, 3, cs_n, rd, to);
        check("stall3_cs", 80'(cs_n), 80'(4));
        check("stall3_to", 80'(to), 80'(0));

        send(1'b0, 2'd3, 32'h0, T - 1, cs_n, rd, to);
        check("stall7_cs", 80'(cs_n), 80'(8));
        check("stall7_rsp", 80'({to, rd}), 80'({1'b0, 32'h1234_5678}));

        stuck = 1'b1;
        send(1'b0, 2'd2, 32'h0, 0, cs_n, rd, to);
        check("tmo_cs", 80'(cs_n), 80'(8));
        check("tmo_rsp", 80'({to, rd}), 80'({1'b1, 32'h0}));
        @(negedge clk);
        check("tmo_held", 80'(rsp_timeout), 80'(1));
        stuck = 1'b0;
        send(1'b0, 2'd2, 32'h0, 0, cs_n, rd, to);
        check("after_tmo", 80'({to, rd}), 80'({1'b0, 32'hDEAD_BEEF}));

        send(1'b1, 2'd1, 32'h77, T, cs_n, rd, to);
        check("stall8_tmo", 80'({to, rd}), 80'({1'b1, 32'h0}));

        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_address = 2'd1;
        cmd_writedata = 32'h55;
        stall_n = 10;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid",
              80'({avm_chipselect, avm_write_n, avm_read_n, cmd_ready,
                   busy, rsp_valid}), 80'(6'b011100));
        reset = 1'b0;
        stall_n = 0;
        repeat (3) begin
            @(negedge clk);
            check("rst_no_rsp", 80'(rsp_valid), 80'(0));
        end

        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_address = 2'd0;
        cmd_writedata = 32'h1;
        acc1 = -1;
        acc2 = -1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (acc2 >= 0) cmd_valid = 1'b0;
            else if (acc1 >= 0) cmd_writedata = 32'h0;
            if (cmd_ready && cmd_valid) begin
                if (acc1 < 0) acc1 = cyc;
                else acc2 = cyc;
            end
            if (rsp_valid) pulses++;
            check("b2b_ready_busy", 80'(cmd_ready & busy), 80'(0));
            @(negedge clk);
        end
        check("b2b_gap", 80'(acc2 - acc1), 80'(3));
        check("b2b_pulses", 80'(pulses), 80'(2));

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/avalon_mm_cmd_master.md
Name: avalon_mm_cmd_master

Overview:
- Avalon-MM initiator that turns a simple valid/ready command stream into single-word bus transactions on our memory-mapped peripherals (PIO registers, control/status slaves).
- Lets AGC control logic in fabric drive and poll peripheral registers without the Nios II core.
- One outstanding transaction at a time, with waitrequest handling, a bounded timeout and a one-cycle response pulse.

Parameters:
- ADDR_WIDTH, 2, width of cmd_address and avm_address.
- DATA_WIDTH, 32, width of write and read data.
- TIMEOUT_CYCLES, 255, maximum number of stalled waitrequest cycles before the access is abandoned; 0 disables the timeout.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  input  1  1 = write, 0 = read.
- cmd_address  input  ADDR_WIDTH  target word address.
- cmd_writedata  input  DATA_WIDTH  write data.
- rsp_valid  output  1  one-cycle response strobe.
- rsp_readdata  output  DATA_WIDTH  read result; 0 for writes and timeouts.
- rsp_timeout  output  1  qualifies rsp_valid: access abandoned.
- busy  output  1  high whenever state != IDLE.
- avm_address  output  ADDR_WIDTH  bus address.
- avm_chipselect  output  1  bus select.
- avm_write_n  output  1  active-low write strobe.
- avm_read_n  output  1  active-low read strobe.
- avm_writedata  output  DATA_WIDTH  bus write data.
- avm_readdata  input  DATA_WIDTH  slave read data, zero read latency.
- avm_waitrequest  input  1  slave stall.

Behaviour:
- Reset: state = IDLE, timeout counter = 0.
  - Reset values: cmd_ready=1, rsp_valid=0, rsp_timeout=0, rsp_readdata=0, busy=0.
  - Bus reset values: avm_chipselect=0, avm_write_n=1, avm_read_n=1, avm_address=0, avm_writedata=0.
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- All outputs are registered. States: IDLE, ACCESS, RESP.
- IDLE:
  - cmd_ready=1; bus at idle values.
  - On the handshake edge, latch cmd_write/cmd_address/cmd_writedata, clear the counter and go to ACCESS.
  - From the next cycle: avm_chipselect=1, avm_address and avm_writedata = latched values.
  - Write: avm_write_n=0, avm_read_n=1. Read: avm_read_n=0, avm_write_n=1.
- ACCESS (cmd_ready=0):
  - Sample avm_waitrequest each edge.
  - If 0: the transfer completes this cycle.
    - Read: capture avm_readdata into rsp_readdata.
    - Write: set rsp_readdata=0.
    - Bus returns to idle values next cycle; go to RESP.
  - If 1: hold every bus output stable and increment the counter.
  - If TIMEOUT_CYCLES != 0 and the counter == TIMEOUT_CYCLES-1 while waitrequest=1: abandon the access, set rsp_readdata=0 and rsp_timeout=1, bus to idle, go to RESP.
  - Consequence: a zero-wait-state access occupies exactly one bus cycle.
  - Stall and timeout limits:
    - A slave may stall for at most TIMEOUT_CYCLES-1 cycles and still complete.
    - Waitrequest still high on the TIMEOUT_CYCLES-th bus cycle causes abandonment.
- RESP:
  - rsp_valid=1 for exactly one cycle, cmd_ready=0, then IDLE.
  - rsp_readdata is held until the next response.
  - rsp_timeout is cleared on the next command accept.
- Throughput: 3 cycles per command minimum; a cmd_valid held high is accepted again on the cycle after rsp_valid.
- Commands presented while cmd_ready=0 are ignored; there is no buffering.
- Counter width: enough bits for TIMEOUT_CYCLES; it never wraps, since it stops at terminal count.
- Reset asserted in ACCESS or RESP:
  - Go to IDLE at that edge; bus idle on the next cycle.
  - No rsp_valid is emitted; the in-flight command is lost.
- busy=1 in ACCESS and RESP.

Test Plan:
- Write, no stall: cmd write=1, addr=0, data=0x1, waitrequest=0.
  - Response: one cycle of chipselect=1, write_n=0, address=0, writedata=0x1.
  - Then rsp_valid=1 with rsp_timeout=0 and rsp_readdata=0; cmd_ready back to 1 the following cycle.
- Read, no stall: cmd read addr=0, slave drives readdata=0x00000001.
  - Response: one cycle of read_n=0, then rsp_valid with rsp_readdata=0x1.
  - A read of addr=1 with slave readdata=0 returns 0.
- Stall: waitrequest=1 for 3 cycles on a write of 0xA5A5A5A5.
  - Response: bus held constant for 4 cycles, then rsp_valid with rsp_timeout=0.
- Timeout: TIMEOUT_CYCLES=8, waitrequest stuck at 1.
  - Response: chipselect high exactly 8 cycles, then rsp_valid=1, rsp_timeout=1, rsp_readdata=0.
  - The next command completes normally and clears rsp_timeout.
- Reset mid-access: assert reset during the 2nd stalled cycle.
  - Response: next cycle chipselect=0, write_n=1, read_n=1, cmd_ready=1, busy=0, and no rsp_valid.
- Back-to-back: cmd_valid held high with 2 writes (0x1, then 0x0) to address 0.
  - Response: accepts 3 cycles apart; two rsp_valid pulses; cmd_ready=0 while busy.
